// File: rtl/iter_shifter.sv
// Multi-cycle shifter: left/right fill, arithmetic right, up to STEP bits per cycle,
// driven by a start/busy/done handshake. Define SHIFTER_ROTATE_EN to make op=11 rotate right.
module iter_shifter #(
    parameter int WIDTH = 32,
    parameter int SH_W  = $clog2(WIDTH),
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [SH_W-1:0]  shAmt,
    input  logic             shBit,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    // One extra bit so STEP == WIDTH is representable in the step arithmetic
    localparam logic [SH_W:0]    STEP_C = (SH_W+1)'(STEP);
    localparam logic [WIDTH-1:0] ALL1   = '1;

    state_t          state, state_nx;
    logic [SH_W-1:0] cnt;
    logic            fill;
    logic [1:0]      op_q;
    logic            accept;
    logic [SH_W:0]   cnt_ext, k;
    logic [WIDTH-1:0] shifted;

`ifdef SHIFTER_ROTATE_EN
    localparam logic [SH_W:0] WIDTH_C = (SH_W+1)'(WIDTH);
    logic [SH_W:0] rot_amt;
    assign rot_amt = WIDTH_C - k;
`endif

    assign cnt_ext = {1'b0, cnt};
    assign k       = (cnt_ext < STEP_C) ? cnt_ext : STEP_C;
    assign busy    = (state == S_SHIFT);
    assign done    = (state == S_DONE);

    always_comb begin
        shifted = out;
        if (op_q == 2'b00)
            shifted = (out << k) | (~(ALL1 << k) & {WIDTH{fill}});
`ifdef SHIFTER_ROTATE_EN
        else if (op_q == 2'b11)
            shifted = (out >> k) | (out << rot_amt);
`endif
        else
            shifted = (out >> k) | (~(ALL1 >> k) & {WIDTH{fill}});
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_nx = S_IDLE;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = (shAmt != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: if (cnt_ext <= STEP_C) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= '0;
            cnt  <= '0;
            fill <= 1'b0;
            op_q <= 2'b00;
        end else if (accept) begin
            out  <= in;
            cnt  <= shAmt;
            // Arithmetic right folds into the fill bit: the operand MSB as seen at start
            fill <= (op == 2'b10) ? in[WIDTH-1] : shBit;
            op_q <= op;
        end else if (state == S_SHIFT) begin
            out <= shifted;
            cnt <= cnt - k[SH_W-1:0];
        end
    end

endmodule
